// File: rtl/fmr_scrub_ctrl.sv
// fmr_scrub_ctrl: sticky redundant-pair mismatch flags with a
// round-robin report/clear scan engine and saturating error count.
module fmr_scrub_ctrl #(
  parameter int N      = 8,
  parameter int CNT_W  = 8,
  parameter int THRESH = 4,
  localparam int PW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     x,
  input  logic [N-1:0]     z,
  input  logic             en,
  input  logic             rpt_ready,
  input  logic             cnt_clr,
  output logic [N-1:0]     flags,
  output logic             rpt_valid,
  output logic [PW-1:0]    rpt_idx,
  output logic [CNT_W-1:0] err_cnt,
  output logic             fault
);

  typedef enum logic [1:0] {
    SCAN,
    REPORT,
    CLEAR
  } state_t;

  localparam logic [CNT_W-1:0] CMAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TH    = CNT_W'(THRESH);
  localparam logic [PW-1:0]    PLAST = PW'(N - 1);

  state_t           state;
  state_t           state_n;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    ptr_n;
  logic [PW-1:0]    ptr_inc;
  logic [PW-1:0]    idx_n;
  logic             valid_n;
  logic [N-1:0]     clr_vec;
  logic [N-1:0]     flags_n;
  logic [CNT_W-1:0] cnt_n;
  logic             fault_n;

  assign ptr_inc = (ptr == PLAST) ? '0 : ptr + PW'(1);

  // Scan FSM next state, pointer, report outputs and clear strobe.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    valid_n = rpt_valid;
    idx_n   = rpt_idx;
    clr_vec = '0;
    unique case (state)
      SCAN: begin
        if (en) begin
          if (flags[ptr]) begin
            state_n = REPORT;
            valid_n = 1'b1;
            idx_n   = ptr;
          end else begin
            ptr_n = ptr_inc;
          end
        end
      end
      REPORT: begin
        if (rpt_ready) begin
          state_n = CLEAR;
          valid_n = 1'b0;
        end
      end
      CLEAR: begin
        clr_vec[ptr] = 1'b1;
        ptr_n        = ptr_inc;
        state_n      = SCAN;
      end
      default: state_n = SCAN;
    endcase
  end

  // Flag update (set beats clear), counter and sticky fault.
  always_comb begin
    flags_n = (flags & ~clr_vec) | (x ^ z);
    cnt_n   = err_cnt;
    fault_n = fault | (err_cnt >= TH);
    if (cnt_clr) begin
      cnt_n   = '0;
      fault_n = 1'b0;
    end else if (state == CLEAR && err_cnt != CMAX) begin
      cnt_n = err_cnt + CNT_W'(1);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SCAN;
      ptr       <= '0;
      flags     <= '0;
      rpt_valid <= 1'b0;
      rpt_idx   <= '0;
      err_cnt   <= '0;
      fault     <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      flags     <= flags_n;
      rpt_valid <= valid_n;
      rpt_idx   <= idx_n;
      err_cnt   <= cnt_n;
      fault     <= fault_n;
    end
  end

endmodule

// File: tb/tb_fmr_scrub_ctrl.sv
// tb_fmr_scrub_ctrl: scoreboard + table bench for fmr_scrub_ctrl,
// with a second narrow-counter instance for saturation.
module tb_fmr_scrub_ctrl;

  localparam int N = 8;

  logic       clk;
  logic       rst_n;
  logic [7:0] x;
  logic [7:0] z;
  logic       en;
  logic       rpt_ready;
  logic       cnt_clr;
  logic [7:0] flags;
  logic       rpt_valid;
  logic [2:0] rpt_idx;
  logic [7:0] err_cnt;
  logic       fault;
  logic [7:0] flags2;
  logic       valid2;
  logic [2:0] idx2;
  logic [1:0] err2;
  logic       fault2;

  fmr_scrub_ctrl #(.N(8), .CNT_W(8), .THRESH(4)) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .z(z), .en(en),
    .rpt_ready(rpt_ready), .cnt_clr(cnt_clr),
    .flags(flags), .rpt_valid(rpt_valid), .rpt_idx(rpt_idx),
    .err_cnt(err_cnt), .fault(fault)
  );

  fmr_scrub_ctrl #(.N(8), .CNT_W(2), .THRESH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .x(x), .z(z), .en(en),
    .rpt_ready(rpt_ready), .cnt_clr(cnt_clr),
    .flags(flags2), .rpt_valid(valid2), .rpt_idx(idx2),
    .err_cnt(err2), .fault(fault2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] mis;
    int         first;
    int         nrep;
    int         ecnt;
  } vec_t;

  int ncmp = 0;
  int nfail = 0;
  int exp_q[$];
  int mptr = 0;
  int mcnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic pulse(input logic [7:0] m);
    x = m;
    @(posedge clk);
    #1 x = 8'h00;
  endtask

  task automatic push_order(input logic [7:0] m);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (mptr + k) % N;
      if (m[i]) exp_q.push_back(i);
    end
  endtask

  // Pop expected reports on each handshake; ends just after the
  // CLEAR edge of the last one, with en dropped to freeze the pointer.
  task automatic drain(input logic [7:0] watch,
                       output int first, output int npop);
    int cyc;
    int bad;
    int e;
    cyc = 0;
    bad = 0;
    first = -1;
    npop = 0;
    while (exp_q.size() > 0 && cyc < 40 * N) begin
      @(negedge clk);
      cyc++;
      if ((flags & watch) != watch) bad++;
      if (rpt_valid && rpt_ready) begin
        e = exp_q.pop_front();
        if (npop == 0) first = int'(rpt_idx);
        npop++;
        chk("rpt_idx", int'(rpt_idx), e);
        mptr = (e + 1) % N;
        mcnt++;
      end
    end
    if (exp_q.size() > 0) begin
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    @(posedge clk);
    @(posedge clk);
    #1 en = 1'b0;
    if (watch != 8'h00) chk("flag_held", bad, 0);
  endtask

  task automatic settle_check();
    @(posedge clk);
    #1;
    chk("err_cnt", int'(err_cnt), sat(mcnt, 255));
    chk("err_cnt_w2", int'(err2), sat(mcnt, 3));
    chk("fault", int'(fault), int'(mcnt >= 4));
    chk("fault_w2", int'(fault2), int'(mcnt >= 2));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mptr = 0;
    mcnt = 0;
    exp_q.delete();
  endtask

  initial begin
    vec_t tbl[4];
    int   f;
    int   n;
    int   w;
    int   bad;

    tbl[0] = '{8'h01, 0, 1, 4};
    tbl[1] = '{8'h18, 3, 2, 6};
    tbl[2] = '{8'hA2, 5, 3, 9};
    tbl[3] = '{8'hFF, 2, 8, 17};

    x = 8'h00;
    z = 8'h00;
    en = 1'b0;
    rpt_ready = 1'b0;
    cnt_clr = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("async_reset_valid", int'(rpt_valid), 0);
    do_reset();

    // Reset values and idle scanning.
    chk("rst_flags", int'(flags), 0);
    chk("rst_valid", int'(rpt_valid), 0);
    chk("rst_idx", int'(rpt_idx), 0);
    chk("rst_cnt", int'(err_cnt), 0);
    chk("rst_fault", int'(fault), 0);
    en = 1'b1;
    bad = 0;
    repeat (3 * N) begin
      @(negedge clk);
      if (rpt_valid) bad++;
    end
    chk("idle_valid", bad, 0);
    do_reset();

    // Backpressure: flags 2 and 6, ready held low.
    en = 1'b0;
    pulse(8'h44);
    en = 1'b1;
    w = 0;
    while (!rpt_valid && w < 2 * N) begin
      @(negedge clk);
      w++;
    end
    chk("bp_idx", int'(rpt_idx), 2);
    bad = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (!rpt_valid || rpt_idx != 3'd2) bad++;
    end
    chk("bp_stable", bad, 0);
    push_order(8'h44);
    rpt_ready = 1'b1;
    drain(8'h00, f, n);
    chk("bp_first", f, 2);
    chk("bp_nrep", n, 2);
    chk("bp_flags", int'(flags), 0);
    settle_check();

    // Single mismatch while scanning.
    en = 1'b1;
    exp_q.push_back(5);
    pulse(8'h20);
    chk("single_flag_set", int'(flags[5]), 1);
    drain(8'h00, f, n);
    chk("single_nrep", n, 1);
    chk("single_flags", int'(flags), 0);
    settle_check();

    // Table of mismatch patterns, round-robin order from pointer.
    for (int t = 0; t < 4; t++) begin
      pulse(tbl[t].mis);
      push_order(tbl[t].mis);
      en = 1'b1;
      drain(8'h00, f, n);
      chk("tbl_first", f, tbl[t].first);
      chk("tbl_nrep", n, tbl[t].nrep);
      chk("tbl_flags", int'(flags), 0);
      chk("tbl_cnt", int'(err_cnt), tbl[t].ecnt);
      settle_check();
    end

    // Threshold: fault one edge after count reaches 4.
    cnt_clr = 1'b1;
    @(posedge clk);
    #1 cnt_clr = 1'b0;
    mcnt = 0;
    chk("clr_cnt", int'(err_cnt), 0);
    chk("clr_fault", int'(fault), 0);
    pulse(8'h0F);
    push_order(8'h0F);
    en = 1'b1;
    drain(8'h00, f, n);
    chk("th_cnt", int'(err_cnt), 4);
    chk("th_fault_early", int'(fault), 0);
    @(posedge clk);
    #1;
    chk("th_fault", int'(fault), 1);

    // cnt_clr coinciding with the fifth CLEAR edge.
    pulse(8'h10);
    en = 1'b1;
    w = 0;
    while (!(rpt_valid && rpt_ready) && w < 4 * N) begin
      @(negedge clk);
      w++;
    end
    chk("th5_idx", int'(rpt_idx), 4);
    @(posedge clk);
    #1 cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    en = 1'b0;
    mptr = 5;
    mcnt = 0;
    chk("th5_cnt", int'(err_cnt), 0);
    chk("th5_flags", int'(flags), 0);
    settle_check();

    // Persistent mismatch on channel 3: set beats clear.
    x = 8'h08;
    en = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) exp_q.push_back(3);
    drain(8'h08, f, n);
    chk("sw_nrep", n, 3);
    chk("sw_flag", int'(flags[3]), 1);
    chk("sw_cnt", int'(err_cnt), 3);
    x = 8'h00;
    exp_q.push_back(3);
    en = 1'b1;
    drain(8'h00, f, n);
    chk("sw_flags_end", int'(flags), 0);
    settle_check();

    // Enable low: no report, pointer frozen.
    pulse(8'h02);
    bad = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (rpt_valid) bad++;
    end
    chk("en_off_valid", bad, 0);
    chk("en_off_flags", int'(flags), 2);
    en = 1'b1;
    w = 0;
    while (!rpt_valid && w < 2 * N) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("en_latency", w, ((1 - mptr + N) % N) + 1);
    exp_q.push_back(1);
    drain(8'h00, f, n);
    chk("en_nrep", n, 1);
    settle_check();

    // Reset asserted mid-REPORT.
    rpt_ready = 1'b0;
    pulse(8'h10);
    en = 1'b1;
    w = 0;
    while (!rpt_valid && w < 4 * N) begin
      @(negedge clk);
      w++;
    end
    chk("mid_valid_pre", int'(rpt_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_valid", int'(rpt_valid), 0);
    chk("mid_flags", int'(flags), 0);
    chk("mid_idx", int'(rpt_idx), 0);
    chk("mid_cnt", int'(err_cnt), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
